// File: rtl/arb2_pkg.sv
// Shared types and constants for the two-source packet arbiter.
package arb2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } arb2_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/arb2_beat_cnt.sv
// Beats-in-packet counter with the forced-release (overrun) compare.
module arb2_beat_cnt #(
  parameter int MAX_BEATS = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_accept,
  input  logic i_last,
  output logic o_overrun
);

  localparam int W = $clog2(MAX_BEATS + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX_BEATS - 1);

  logic [W-1:0] r_beat_cnt;

  // Only the final permitted beat without last trips the overrun.
  assign o_overrun = i_accept && !i_last && (r_beat_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (i_accept) begin
      if (i_last || o_overrun) r_beat_cnt <= '0;
      else                     r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/arb2_sel_ctrl.sv
// Packet-level round-robin arbiter driving the select pair of a 2:1 data mux.
// Optional per-source packet counters are enabled by defining ARB2_PKT_CNT_EN.
module arb2_sel_ctrl #(
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic             sel1,
  output logic             sel2,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             err_overrun,
  output logic [CNT_W-1:0] pkt_cnt_a,
  output logic [CNT_W-1:0] pkt_cnt_b
);

  import arb2_pkg::*;

  arb2_state_t r_state;
  logic        r_prio;
  logic        r_err;
  logic        w_x_valid;
  logic        w_x_last;
  logic        w_accept;
  logic        w_overrun;
  logic        w_src;

  always_comb begin
    w_x_valid = 1'b0;
    w_x_last  = 1'b0;
    case (r_state)
      GNT_A: begin
        w_x_valid = a_valid;
        w_x_last  = a_last;
      end
      GNT_B: begin
        w_x_valid = b_valid;
        w_x_last  = b_last;
      end
      default: ;
    endcase
  end

  // Selects decode from the state register only, so they cannot glitch on inputs.
  assign sel1        = (r_state == GNT_A);
  assign sel2        = (r_state == GNT_B);
  assign a_ready     = sel1 & out_ready;
  assign b_ready     = sel2 & out_ready;
  assign out_valid   = w_x_valid;
  assign out_last    = w_x_last;
  assign err_overrun = r_err;
  assign w_accept    = w_x_valid & out_ready;
  assign w_src       = sel2 ? SRC_B : SRC_A;

  arb2_beat_cnt #(
    .MAX_BEATS(MAX_BEATS)
  ) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_last   (w_x_last),
    .o_overrun(w_overrun)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= SRC_A;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (a_valid && (!b_valid || r_prio == SRC_A)) r_state <= GNT_A;
          else if (b_valid)                             r_state <= GNT_B;
        end
        GNT_A, GNT_B: begin
          // Release always passes through IDLE, giving the mux a clean select change.
          if (w_accept && (w_x_last || w_overrun)) begin
            r_state <= IDLE;
            r_prio  <= other_src(w_src);
            r_err   <= w_overrun;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB2_PKT_CNT_EN
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (w_accept && w_x_last) begin
      if (w_src == SRC_A) r_cnt_a <= r_cnt_a + 1'b1;
      else                r_cnt_b <= r_cnt_b + 1'b1;
    end
  end

  assign pkt_cnt_a = r_cnt_a;
  assign pkt_cnt_b = r_cnt_b;
`else
  assign pkt_cnt_a = '0;
  assign pkt_cnt_b = '0;
`endif

endmodule

// File: doc/arb2_sel_ctrl.md
Name: arb2_sel_ctrl

Overview:
- Packet-level round-robin arbiter between two streaming sources, A and B, that share one datapath.
- Drives the one-hot select pair of the downstream 2:1 data mux: sel1 picks A, sel2 picks B. Neither asserted means the mux output is don't-care.
- Holds a grant for a whole packet (until the last beat is accepted) and forwards valid/ready/last between the winning source and the single consumer.
- Sits directly upstream of the mux, which carries the data words; this block never touches data.

Parameters:
- MAX_BEATS, 256: maximum beats per packet before a forced release; must be ≥1.
- CNT_W, 16: width of the optional packet counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  source A beat valid
- a_last  in  1  source A final beat of packet
- a_ready  out  1  source A beat accepted
- b_valid  in  1  source B beat valid
- b_last  in  1  source B final beat of packet
- b_ready  out  1  source B beat accepted
- sel1  out  1  mux select, source A
- sel2  out  1  mux select, source B
- out_valid  out  1  beat valid to consumer
- out_last  out  1  final beat to consumer
- out_ready  in  1  consumer accepts beat
- err_overrun  out  1  one-cycle pulse on forced release
- pkt_cnt_a  out  CNT_W  packets completed from A (see Optional Feature)
- pkt_cnt_b  out  CNT_W  packets completed from B (see Optional Feature)

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, prio = A, beat_cnt = 0.
  - All outputs 0: sel1, sel2, a_ready, b_ready, out_valid, out_last, err_overrun, counters.
- States are IDLE, GNT_A and GNT_B, held in a registered state variable.
  - sel1 = (state==GNT_A); sel2 = (state==GNT_B).
  - The decode is from the register only, so sel1 and sel2 are never both 1 and never glitch on inputs.
- IDLE:
  - Only a_valid → GNT_A. Only b_valid → GNT_B.
  - Both valid → go to the source named by prio.
  - Neither → stay in IDLE.
  - Grant latency: one cycle from valid to the select being asserted. No beat transfers in IDLE.
- GNT_x forwarding (x = granted source):
  - out_valid = x_valid; out_last = x_last; x_ready = out_ready.
  - The other source's ready is 0.
- Beat accepted (x_valid & out_ready):
  - Increment beat_cnt.
  - If x_last → go to IDLE, set prio to the other source, clear beat_cnt.
- Back-to-back packets: there is always exactly one IDLE cycle between packets. This gives a registered select change ahead of the mux.
- Overrun:
  - Condition: a beat is accepted with beat_cnt==MAX_BEATS-1 and x_last=0.
  - Action: force IDLE, flip prio, clear beat_cnt, pulse err_overrun for 1 cycle.
  - The packet is not counted as completed.
- x_valid dropping mid-packet: the grant is held; no timeout.
- Reset mid-packet: the packet is abandoned immediately and the block behaves exactly as after power-up.
- beat_cnt width: $clog2(MAX_BEATS+1) bits; it never wraps.

Optional Feature:
- Macro: ARB2_PKT_CNT_EN.
- Defined:
  - pkt_cnt_a/pkt_cnt_b increment by 1 on each accepted last beat from their source.
  - They wrap modulo 2^CNT_W and reset to 0.
  - Overruns do not increment them.
- Undefined: the ports remain, tied to 0, and no counter flops are inferred.

Decomposition:
- Shared package arb2_pkg:
  - state encoding typedef (IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10);
  - source-id constants SRC_A=1'b0, SRC_B=1'b1.
- One sub-module: arb2_beat_cnt, the beat counter with its overrun compare, parameterised by MAX_BEATS.
- FSM and handshake muxing stay in the top module.

Test Plan:
- Single packet:
  - Stimulus: reset, then a_valid=1 with 3 beats (last on beat 3), out_ready=1.
  - Response: sel1=1 from cycle 1. Beats accepted on cycles 1-3. Back to IDLE on cycle 4. sel2 never 1.
- Contention round-robin:
  - Stimulus: a_valid and b_valid both held with 2-beat packets, out_ready=1.
  - Response: grants in the order A, B, A, B, with exactly one idle cycle between each. sel1/sel2 never both 1.
- Backpressure:
  - Stimulus: B holds a 4-beat packet, out_ready toggles 1,0,1,0,…
  - Response: b_ready mirrors out_ready. Exactly 4 accepted beats. Grant held throughout. a_ready=0 throughout.
- Overrun:
  - Stimulus: MAX_BEATS=4; A sends 5 beats with no last.
  - Response: err_overrun pulses one cycle after beat 4 is accepted. Next grant goes to B if b_valid, else back to A from IDLE. pkt_cnt_a unchanged.
- Reset mid-packet:
  - Stimulus: assert rst asynchronously on beat 2 of an A packet.
  - Response: all outputs 0 immediately (before the next clk edge). After release, prio=A and counters are 0.
- Counters (ARB2_PKT_CNT_EN defined, CNT_W=2):
  - Stimulus: 5 A packets.
  - Response: pkt_cnt_a reads 1,2,3,0,1.
  - Without the macro, pkt_cnt_a and pkt_cnt_b stay at 0.
